// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment counter.
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ALARM = 2'd2
    } state_e;

    // All segments off (active-low)
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Status LED patterns for leds[3:0]
    localparam logic [3:0] LED_IDLE  = 4'b0001;
    localparam logic [3:0] LED_RUN   = 4'b0011;
    localparam logic [3:0] LED_ALARM = 4'b1111;

    // Active-low glyphs {g,f,e,d,c,b,a} for 0-9, A b C d E F
    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [3:0] led_pattern(input state_e s);
        case (s)
            ST_RUN:   return LED_RUN;
            ST_ALARM: return LED_ALARM;
            default:  return LED_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational 4-bit value to active-low 7-segment glyph.
module seg7_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_c
);

    // Table lookup
    always_comb begin
        seg_c = SEG_GLYPH[nibble];
    end

endmodule

// File: rtl/seg_mux_counter.sv
// N-digit up/down counter with multiplexed active-low 7-segment display,
// status LEDs and timed wrap alarm buzzer.
// Optional: define SEG_BLANK_LEADING_EN to blank digits above the most
// significant nonzero digit (digit 0 always shown).
module seg_mux_counter
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned RADIX       = 16,
    parameter int unsigned TICK_DIV    = 65536,
    parameter int unsigned SCAN_DIV    = 2048,
    parameter int unsigned ALARM_TICKS = 4,
    parameter int unsigned TONE_BIT    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      up_dn,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   load_val,
    output logic [6:0]                seg_display,
    output logic [NUM_DIGITS-1:0]     digit_select,
    output logic [7:0]                leds,
    output logic                      buzzer,
    output logic                      wrap
);

    localparam int unsigned TICK_W = $clog2(TICK_DIV);
    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned ALM_W  = $clog2(ALARM_TICKS + 1);
    localparam logic [3:0]  MAX_DIGIT = 4'(RADIX - 1);

    logic [TICK_W-1:0]              tick_cnt_q, tick_cnt_d;
    logic [SCAN_W-1:0]              scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]               scan_idx_q, scan_idx_d;
    logic [NUM_DIGITS-1:0][3:0]     digits_q, digits_d, step_c;
    logic [ALM_W-1:0]               alarm_q, alarm_d;
    state_e                         state_q, state_d;
    logic [6:0]                     seg_q, seg_d, glyph_c;
    logic [NUM_DIGITS-1:0]          dsel_q, dsel_d;
    logic [7:0]                     leds_q, leds_d;
    logic                           buzzer_q, buzzer_d;
    logic                           wrap_q, wrap_d;
    logic                           tick_c, scan_tick_c, carry_c;

    // Free-running tick and scan dividers
    always_comb begin
        tick_c      = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
        scan_tick_c = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
        tick_cnt_d  = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
        scan_cnt_d  = scan_tick_c ? '0 : scan_cnt_q + SCAN_W'(1);
    end

    // Ripple increment/decrement; carry out of the top digit means full-range wrap
    always_comb begin
        step_c  = digits_q;
        carry_c = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry_c) begin
                if (up_dn) begin
                    if (digits_q[i] >= MAX_DIGIT) begin
                        step_c[i] = 4'd0;
                    end else begin
                        step_c[i] = digits_q[i] + 4'd1;
                        carry_c   = 1'b0;
                    end
                end else begin
                    if (digits_q[i] == 4'd0) begin
                        step_c[i] = MAX_DIGIT;
                    end else begin
                        step_c[i] = digits_q[i] - 4'd1;
                        carry_c   = 1'b0;
                    end
                end
            end
        end
    end

    // Counter update: load wins over counting and clamps out-of-radix digits
    always_comb begin
        digits_d = digits_q;
        wrap_d   = 1'b0;
        if (load) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digits_d[i] = (load_val[4*i +: 4] > MAX_DIGIT) ? MAX_DIGIT : load_val[4*i +: 4];
            end
        end else if (tick_c && en) begin
            digits_d = step_c;
            wrap_d   = carry_c;
        end
    end

    // Mode FSM next state; a wrap during ALARM restarts the alarm timer
    always_comb begin
        state_d = state_q;
        alarm_d = alarm_q;
        case (state_q)
            ST_IDLE: begin
                if (wrap_d) begin
                    state_d = ST_ALARM;
                    alarm_d = '0;
                end else if (en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (wrap_d) begin
                    state_d = ST_ALARM;
                    alarm_d = '0;
                end else if (!en) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ALARM: begin
                if (wrap_d) begin
                    alarm_d = '0;
                end else if (tick_c) begin
                    if (alarm_q == ALM_W'(ALARM_TICKS - 1)) begin
                        state_d = en ? ST_RUN : ST_IDLE;
                        alarm_d = '0;
                    end else begin
                        alarm_d = alarm_q + ALM_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                alarm_d = '0;
            end
        endcase
    end

    seg7_decoder u_dec (
        .nibble (digits_q[scan_idx_q]),
        .seg_c  (glyph_c)
    );

`ifdef SEG_BLANK_LEADING_EN
    logic [IDX_W-1:0] msd_c;

    // Index of the most significant nonzero digit (0 when all zero)
    always_comb begin
        msd_c = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digits_q[i] != 4'd0) begin
                msd_c = IDX_W'(i);
            end
        end
    end
`endif

    // Display scan, glyph select and status outputs, all from the same cycle's state
    always_comb begin
        scan_idx_d = scan_idx_q;
        if (scan_tick_c) begin
            scan_idx_d = (scan_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
        end
        dsel_d             = '1;
        dsel_d[scan_idx_q] = 1'b0;
`ifdef SEG_BLANK_LEADING_EN
        seg_d = (scan_idx_q > msd_c) ? SEG_BLANK : glyph_c;
`else
        seg_d = glyph_c;
`endif
        leds_d   = {digits_q[NUM_DIGITS-1], led_pattern(state_q)};
        buzzer_d = (state_q == ST_ALARM) && tick_cnt_q[TONE_BIT];
    end

    // All state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q <= '0;
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
            digits_q   <= '0;
            alarm_q    <= '0;
            state_q    <= ST_IDLE;
            seg_q      <= SEG_BLANK;
            dsel_q     <= '1;
            leds_q     <= '0;
            buzzer_q   <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            digits_q   <= digits_d;
            alarm_q    <= alarm_d;
            state_q    <= state_d;
            seg_q      <= seg_d;
            dsel_q     <= dsel_d;
            leds_q     <= leds_d;
            buzzer_q   <= buzzer_d;
            wrap_q     <= wrap_d;
        end
    end

    assign seg_display  = seg_q;
    assign digit_select = dsel_q;
    assign leds         = leds_q;
    assign buzzer       = buzzer_q;
    assign wrap         = wrap_q;

endmodule

// File: tb/tb_seg_mux_counter.sv
// Scoreboard bench for seg_mux_counter: stimulus schedules expected output
// values against the bench's own cycle count; a monitor compares them.
module tb_seg_mux_counter;

    localparam int unsigned ND = 4;

    // Glyph expected for a leading zero digit
`ifdef SEG_BLANK_LEADING_EN
    localparam logic [7:0] LZ = 8'h7F;
`else
    localparam logic [7:0] LZ = 8'h40;
`endif

    localparam int SIG_SEG = 0, SIG_DSEL = 1, SIG_LEDS = 2, SIG_BUZ = 3, SIG_WRAP = 4;

    typedef struct {
        int         cyc;
        string      name;
        int         sig;
        logic [7:0] val;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              en = 1'b0;
    logic              up_dn = 1'b1;
    logic              load = 1'b0;
    logic [4*ND-1:0]   load_val = '0;
    logic [6:0]        seg_display;
    logic [ND-1:0]     digit_select;
    logic [7:0]        leds;
    logic              buzzer;
    logic              wrap;

    exp_t       sb[$];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    logic [7:0] got;

    seg_mux_counter #(
        .NUM_DIGITS (ND),
        .RADIX      (10),
        .TICK_DIV   (4),
        .SCAN_DIV   (2),
        .ALARM_TICKS(2),
        .TONE_BIT   (0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .up_dn        (up_dn),
        .load         (load),
        .load_val     (load_val),
        .seg_display  (seg_display),
        .digit_select (digit_select),
        .leds         (leds),
        .buzzer       (buzzer),
        .wrap         (wrap)
    );

    always #5 clk = ~clk;

    // Bench cycle count: 0 in the last reset cycle, so tick cycles are cyc%4==3
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic [7:0] observe(input int s);
        case (s)
            SIG_SEG:  return {1'b0, seg_display};
            SIG_DSEL: return {4'b0, digit_select};
            SIG_LEDS: return leds;
            SIG_BUZ:  return {7'b0, buzzer};
            default:  return {7'b0, wrap};
        endcase
    endfunction

    function automatic void ex(input int c, input string n, input int s, input logic [7:0] v);
        exp_t e;
        e.cyc  = c;
        e.name = $sformatf("%s@%0d", n, c);
        e.sig  = s;
        e.val  = v;
        sb.push_back(e);
    endfunction

    // Monitor: compare every scheduled expectation whose cycle has arrived
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                got = observe(sb[i].sig);
                total++;
                if (sb[i].cyc < cyc) begin
                    bad++;
                    $display("FAIL %s: slot passed (now cyc %0d)", sb[i].name, cyc);
                end else if (got !== sb[i].val) begin
                    bad++;
                    $display("FAIL %s: got %02h want %02h", sb[i].name, got, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        ex(0, "rst_seg",  SIG_SEG,  8'h7F);
        ex(0, "rst_dsel", SIG_DSEL, 8'h0F);
        ex(0, "rst_leds", SIG_LEDS, 8'h00);
        ex(0, "rst_buz",  SIG_BUZ,  8'h00);
        ex(0, "rst_wrap", SIG_WRAP, 8'h00);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Scan of 1234 with counting disabled
        ex(9,  "scan_dsel", SIG_DSEL, 8'h0E); ex(9,  "scan_seg", SIG_SEG, 8'h19);
        ex(10, "scan_dsel", SIG_DSEL, 8'h0E); ex(10, "scan_seg", SIG_SEG, 8'h19);
        ex(11, "scan_dsel", SIG_DSEL, 8'h0D); ex(11, "scan_seg", SIG_SEG, 8'h30);
        ex(12, "scan_dsel", SIG_DSEL, 8'h0D); ex(12, "scan_seg", SIG_SEG, 8'h30);
        ex(13, "scan_dsel", SIG_DSEL, 8'h0B); ex(13, "scan_seg", SIG_SEG, 8'h24);
        ex(14, "scan_dsel", SIG_DSEL, 8'h0B); ex(14, "scan_seg", SIG_SEG, 8'h24);
        ex(15, "scan_dsel", SIG_DSEL, 8'h07); ex(15, "scan_seg", SIG_SEG, 8'h79);
        ex(16, "scan_dsel", SIG_DSEL, 8'h07); ex(16, "scan_seg", SIG_SEG, 8'h79);
        ex(17, "scan_dsel", SIG_DSEL, 8'h0E); ex(17, "scan_seg", SIG_SEG, 8'h19);
        ex(10, "scan_leds", SIG_LEDS, 8'h11);
        wait_cyc(2);  load_val = 16'h1234; load = 1'b1;
        wait_cyc(3);  load = 1'b0;

        // Leading digits of 0007, then all-zero value
        ex(25, "lz7_d0", SIG_SEG, 8'h78); ex(25, "lz7_sel0", SIG_DSEL, 8'h0E);
        ex(27, "lz7_d1", SIG_SEG, LZ);
        ex(29, "lz7_d2", SIG_SEG, LZ);
        ex(31, "lz7_d3", SIG_SEG, LZ);   ex(31, "lz7_sel3", SIG_DSEL, 8'h07);
        ex(41, "lz0_d0", SIG_SEG, 8'h40);
        ex(43, "lz0_d1", SIG_SEG, LZ);
        ex(47, "lz0_d3", SIG_SEG, LZ);
        wait_cyc(20); load_val = 16'h0007; load = 1'b1;
        wait_cyc(21); load = 1'b0;
        wait_cyc(34); load_val = 16'h0000; load = 1'b1;
        wait_cyc(35); load = 1'b0;

        // 0099 + one tick -> 0100, no wrap, RUN leds
        ex(51, "inc_leds", SIG_LEDS, 8'h03);
        ex(52, "inc_wrap", SIG_WRAP, 8'h00);
        ex(57, "inc_d0", SIG_SEG, 8'h40);
        ex(59, "inc_d1", SIG_SEG, 8'h40);
        ex(61, "inc_d2", SIG_SEG, 8'h79);
        ex(63, "inc_d3", SIG_SEG, LZ);
        wait_cyc(48); load_val = 16'h0099; load = 1'b1; en = 1'b1; up_dn = 1'b1;
        wait_cyc(49); load = 1'b0;
        wait_cyc(52); en = 1'b0;

        // Load 00F3 on a tick cycle: clamp to 0093, no increment
        ex(68, "ldtk_wrap", SIG_WRAP, 8'h00);
        ex(73, "ldtk_d0", SIG_SEG, 8'h30);
        ex(75, "ldtk_d1", SIG_SEG, 8'h10);
        ex(77, "ldtk_d2", SIG_SEG, LZ);
        ex(79, "ldtk_d3", SIG_SEG, LZ);
        wait_cyc(67); load_val = 16'h00F3; load = 1'b1; en = 1'b1;
        wait_cyc(68); load = 1'b0; en = 1'b0;

        // 9999 up -> 0000 with wrap, ALARM for 2 ticks, buzzer tone
        ex(83, "upw_wrap", SIG_WRAP, 8'h00);
        ex(84, "upw_wrap", SIG_WRAP, 8'h01);
        ex(84, "upw_leds", SIG_LEDS, 8'h93);
        ex(85, "upw_wrap", SIG_WRAP, 8'h00);
        ex(85, "upw_leds", SIG_LEDS, 8'h0F);
        ex(85, "upw_buz",  SIG_BUZ,  8'h00);
        ex(86, "upw_buz",  SIG_BUZ,  8'h01);
        ex(87, "upw_buz",  SIG_BUZ,  8'h00);
        ex(92, "upw_buz",  SIG_BUZ,  8'h01);
        ex(92, "upw_leds", SIG_LEDS, 8'h0F);
        ex(93, "upw_leds", SIG_LEDS, 8'h03);
        ex(93, "upw_buz",  SIG_BUZ,  8'h00);
        wait_cyc(80); load_val = 16'h9999; load = 1'b1; en = 1'b1; up_dn = 1'b1;
        wait_cyc(81); load = 1'b0;

        // 0000 down -> 9999 with wrap, ALARM then back to RUN
        ex(99,  "dnw_wrap", SIG_WRAP, 8'h00);
        ex(100, "dnw_wrap", SIG_WRAP, 8'h01);
        ex(100, "dnw_leds", SIG_LEDS, 8'h03);
        ex(101, "dnw_wrap", SIG_WRAP, 8'h00);
        ex(101, "dnw_leds", SIG_LEDS, 8'h9F);
        ex(102, "dnw_buz",  SIG_BUZ,  8'h01);
        ex(108, "dnw_leds", SIG_LEDS, 8'h9F);
        ex(109, "dnw_leds", SIG_LEDS, 8'h93);
        ex(109, "dnw_buz",  SIG_BUZ,  8'h00);
        wait_cyc(96); load_val = 16'h0000; load = 1'b1; up_dn = 1'b0;
        wait_cyc(97); load = 1'b0;
        wait_cyc(110); en = 1'b0;

        // Drain scoreboard with a bounded wait
        for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        foreach (sb[i]) begin
            total++;
            bad++;
            $display("FAIL %s: never compared (timeout)", sb[i].name);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
